event_fetch: RTL and testbench
==============================

EVENT_FETCH -- requirements
Module: event_fetch

Interface
REQ-001 Parameter data_wd, default 32: event entry width, equal to the Event Queue entry width.
REQ-002 Parameter hi, default 15: TIME field high bit within an entry.
REQ-003 Parameter lo, default 0: TIME field low bit; time_wd = hi-lo+1.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 en  in  1  fetch enable; 0 freezes new extractions and time advance.
REQ-007 eq_ev  in  data_wd  Event Queue head entry (EV_out).
REQ-008 eq_dv  in  1  eq_ev valid.
REQ-009 eq_busy_rd  in  1  queue cannot accept an extract this cycle.
REQ-010 eq_empty  in  1  queue empty.
REQ-011 eq_cs  out  1  queue chip select, one-cycle pulse per extract.
REQ-012 eq_op  out  1  queue operation; always EXTRACT_CMD.
REQ-013 ev_out  out  data_wd  event issued downstream.
REQ-014 ev_valid  out  1  ev_out valid.
REQ-015 ev_ready  in  1  downstream accepts ev_out.
REQ-016 sim_time  out  time_wd  current simulation time.
REQ-017 time_adv  out  1  one-cycle pulse when sim_time changes.
REQ-018 done  out  1  queue empty, output register empty, FSM idle.
REQ-019 err  out  1  sticky causality error; present only with TIME_CHECK_EN.

Function
REQ-020 The FSM SHALL have three states: IDLE, EXTRACT, SETTLE.
REQ-021 In IDLE, when en=1, eq_dv=1, eq_busy_rd=0, head TIME equals sim_time, and the output register is free or freeing this cycle (ev_valid=0 or ev_ready=1), the block SHALL assert eq_cs for one cycle, latch eq_ev into ev_out, set ev_valid next cycle, and enter EXTRACT.
REQ-022 EXTRACT SHALL last exactly one cycle and then go to SETTLE, with eq_cs=0.
REQ-023 SETTLE SHALL hold until eq_busy_rd=0 and then return to IDLE, so that at most one extract is in flight.
REQ-024 In IDLE, when en=1, eq_dv=1, eq_busy_rd=0, head TIME > sim_time, ev_valid=0 and no extract is issued, the block SHALL load sim_time with head TIME and pulse time_adv for one cycle; no extract occurs that cycle.
REQ-025 ev_valid SHALL stay high, with ev_out stable, until ev_ready=1; ev_valid and ev_ready both high SHALL complete a transfer.
REQ-026 Extract-to-ev_valid latency SHALL be 1 cycle; back-to-back same-time events SHALL issue no faster than once per 3 cycles.
REQ-027 TIME comparison SHALL be unsigned over time_wd bits; sim_time SHALL NOT wrap and SHALL never decrease.
REQ-028 With eq_dv=0 or eq_empty=1, no extract or time advance SHALL occur.
REQ-029 done SHALL be 1 iff eq_empty=1, ev_valid=0 and state=IDLE.
REQ-030 en falling mid-EXTRACT or SETTLE SHALL NOT abort the in-flight extract; it SHALL only block new actions taken from IDLE.

Reset
REQ-031 Asserting rst (low) SHALL set state=IDLE, eq_cs=0, ev_valid=0, ev_out=0, sim_time=0, time_adv=0 and err=0, regardless of clk.
REQ-032 Reset asserted mid-operation SHALL drop any latched event; the queue is assumed reset in the same cycle.

Configuration
REQ-033 Macro TIME_CHECK_EN: when defined, a head TIME < sim_time SHALL set err (sticky until reset), and the event SHALL still be extracted and issued as if it were on time.
REQ-034 Without TIME_CHECK_EN, there SHALL be no err port, and a head TIME < sim_time SHALL be treated as equal to sim_time.

Structure
REQ-035 EXTRACT_CMD, INSERT_CMD, TRUE and FALSE SHALL come from the shared common_defines include; FSM state encodings SHALL be added there.
REQ-036 A single sub-module, ev_time_cmp, SHALL compare the TIME field against sim_time and output eq, gt and lt.

Verification
REQ-037 Reset, then head TIME=0, eq_dv=1, ev_ready=1 -> eq_cs pulse at cycle 1, ev_valid at cycle 2 with ev_out=head, sim_time=0.
REQ-038 sim_time=0, head TIME=5, ev_valid=0 -> time_adv pulse, sim_time=5, then extract on the next IDLE cycle.
REQ-039 Three TIME=7 events, ev_ready=0 for 10 cycles -> one extract only, ev_out stable; after ready=1, the remaining two are issued 3 cycles apart.
REQ-040 eq_busy_rd=1 for 4 cycles after an extract -> FSM held in SETTLE, no eq_cs.
REQ-041 With TIME_CHECK_EN, sim_time=9 and head TIME=4 -> err=1 and the event is issued; err stays 1 until rst=0.
REQ-042 Assert rst low during SETTLE with ev_valid=1 -> all outputs 0 immediately; done=1 once the queue reports empty.

Source files
------------

// File: rtl/event_fetch_pkg.sv
// -----------------------------------------------------------------------------
// event_fetch_pkg
//   Shared definitions for the event fetch slice: Event Queue command
//   encodings, boolean literals and the fetch FSM state type.
// -----------------------------------------------------------------------------
package event_fetch_pkg;

  localparam logic TRUE        = 1'b1;
  localparam logic FALSE       = 1'b0;

  // Event Queue operation encodings (eq_op)
  localparam logic EXTRACT_CMD = 1'b1;
  localparam logic INSERT_CMD  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXTRACT = 2'd1,
    ST_SETTLE  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ev_time_cmp.sv
// -----------------------------------------------------------------------------
// ev_time_cmp
//   Unsigned comparison of an event's TIME field against the current
//   simulation time.
//   Ports:
//     ev_time   in   time_wd  TIME field of the queue head entry
//     sim_time  in   time_wd  current simulation time
//     eq        out  1        ev_time == sim_time
//     gt        out  1        ev_time >  sim_time
//     lt        out  1        ev_time <  sim_time
// -----------------------------------------------------------------------------
module ev_time_cmp #(
  parameter int unsigned time_wd = 16
) (
  input  logic [time_wd-1:0] ev_time,
  input  logic [time_wd-1:0] sim_time,
  output logic               eq,
  output logic               gt,
  output logic               lt
);

  always_comb begin
    eq = (ev_time == sim_time);
    gt = (ev_time >  sim_time);
    lt = (ev_time <  sim_time);
  end

endmodule

// File: rtl/event_fetch.sv
// -----------------------------------------------------------------------------
// event_fetch
//   Pulls events from the Event Queue head in time order and issues them
//   downstream through a single output register, advancing the simulation
//   time when the head lies in the future. At most one extract is in flight:
//   IDLE -> EXTRACT (one cycle) -> SETTLE (until the queue is not busy).
//
//   Optional feature macro: TIME_CHECK_EN
//     defined   : adds sticky 'err' output, set when a head entry older than
//                 sim_time is extracted (the event is still issued).
//     undefined : no 'err' port; late entries are handled as on-time.
//
//   Ports:
//     clk         in   1        clock, rising edge
//     rst         in   1        asynchronous reset, active low
//     en          in   1        fetch enable (blocks new IDLE actions only)
//     eq_ev       in   data_wd  queue head entry
//     eq_dv       in   1        eq_ev valid
//     eq_busy_rd  in   1        queue cannot accept an extract
//     eq_empty    in   1        queue empty
//     eq_cs       out  1        queue chip select, one pulse per extract
//     eq_op       out  1        queue operation, always EXTRACT_CMD
//     ev_out      out  data_wd  issued event
//     ev_valid    out  1        ev_out valid
//     ev_ready    in   1        downstream accepts ev_out
//     sim_time    out  time_wd  current simulation time
//     time_adv    out  1        pulse when sim_time changes
//     done        out  1        queue empty, output empty, FSM idle
//     err         out  1        sticky causality error (TIME_CHECK_EN only)
// -----------------------------------------------------------------------------
module event_fetch
  import event_fetch_pkg::*;
#(
  parameter int unsigned data_wd = 32,
  parameter int unsigned hi      = 15,
  parameter int unsigned lo      = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [data_wd-1:0] eq_ev,
  input  logic               eq_dv,
  input  logic               eq_busy_rd,
  input  logic               eq_empty,
  output logic               eq_cs,
  output logic               eq_op,
  output logic [data_wd-1:0] ev_out,
  output logic               ev_valid,
  input  logic               ev_ready,
  output logic [hi-lo:0]     sim_time,
  output logic               time_adv,
  output logic               done
`ifdef TIME_CHECK_EN
  ,
  output logic               err
`endif
);

  localparam int unsigned time_wd = hi - lo + 1;

  fetch_state_e       state_q,    state_d;
  logic [data_wd-1:0] ev_out_q,   ev_out_d;
  logic               ev_valid_q, ev_valid_d;
  logic [time_wd-1:0] sim_time_q, sim_time_d;
  logic               time_adv_q, time_adv_d;

  logic t_eq, t_gt, t_lt;
  logic head_ok;
  logic out_free;
  logic fire;
  logic advance;

  ev_time_cmp #(
    .time_wd (time_wd)
  ) u_cmp (
    .ev_time  (eq_ev[hi:lo]),
    .sim_time (sim_time_q),
    .eq       (t_eq),
    .gt       (t_gt),
    .lt       (t_lt)
  );

  always_comb begin
    state_d    = state_q;
    ev_out_d   = ev_out_q;
    ev_valid_d = ev_valid_q && !ev_ready;
    sim_time_d = sim_time_q;
    time_adv_d = FALSE;

    head_ok  = (state_q == ST_IDLE) && en && eq_dv && !eq_empty && !eq_busy_rd;
    out_free = !ev_valid_q || ev_ready;
    // Late heads (lt) are issued as if on time; sim_time never moves back.
    fire     = head_ok && (t_eq || t_lt) && out_free;
    // Time only advances once the output register has fully drained, so an
    // issued event is always presented alongside its own sim_time.
    advance  = head_ok && t_gt && !ev_valid_q;

    case (state_q)
      ST_IDLE:    if (fire) state_d = ST_EXTRACT;
      ST_EXTRACT: state_d = ST_SETTLE;
      ST_SETTLE:  if (!eq_busy_rd) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    if (fire) begin
      ev_out_d   = eq_ev;
      ev_valid_d = TRUE;
    end

    if (advance) begin
      sim_time_d = eq_ev[hi:lo];
      time_adv_d = TRUE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ev_out_q   <= '0;
      ev_valid_q <= FALSE;
      sim_time_q <= '0;
      time_adv_q <= FALSE;
    end else begin
      state_q    <= state_d;
      ev_out_q   <= ev_out_d;
      ev_valid_q <= ev_valid_d;
      sim_time_q <= sim_time_d;
      time_adv_q <= time_adv_d;
    end
  end

`ifdef TIME_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= FALSE;
    end else if (fire && t_lt) begin
      err_q <= TRUE;
    end
  end

  assign err = err_q;
`endif

  // Chip select is combinational from the IDLE decision; qualifying it with
  // rst keeps it low while reset is held, independent of the clock.
  assign eq_cs    = fire && rst;
  assign eq_op    = EXTRACT_CMD;
  assign ev_out   = ev_out_q;
  assign ev_valid = ev_valid_q;
  assign sim_time = sim_time_q;
  assign time_adv = time_adv_q;
  assign done     = eq_empty && !ev_valid_q && (state_q == ST_IDLE);

endmodule

// File: tb/tb_event_fetch.sv
module tb_event_fetch;
  import event_fetch_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned TW = 16;

  logic          clk        = 1'b0;
  logic          rst        = 1'b0;
  logic          en         = 1'b0;
  logic [DW-1:0] eq_ev      = '0;
  logic          eq_dv      = 1'b0;
  logic          eq_busy_rd = 1'b0;
  logic          eq_empty   = 1'b1;
  logic          ev_ready   = 1'b0;
  logic          eq_cs;
  logic          eq_op;
  logic [DW-1:0] ev_out;
  logic          ev_valid;
  logic [TW-1:0] sim_time;
  logic          time_adv;
  logic          done;
`ifdef TIME_CHECK_EN
  logic          err;
`endif

  event_fetch #(
    .data_wd (DW),
    .hi      (15),
    .lo      (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .eq_ev      (eq_ev),
    .eq_dv      (eq_dv),
    .eq_busy_rd (eq_busy_rd),
    .eq_empty   (eq_empty),
    .eq_cs      (eq_cs),
    .eq_op      (eq_op),
    .ev_out     (ev_out),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .sim_time   (sim_time),
    .time_adv   (time_adv),
    .done       (done)
`ifdef TIME_CHECK_EN
    ,
    .err        (err)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [DW-1:0] ev;
    logic [TW-1:0] t;
  } exp_t;

  logic [DW-1:0] src_q[$];      // contents of the modelled Event Queue
  exp_t          sb[$];         // expected downstream transfers, in order
  logic [TW-1:0] model_time = '0;
  logic          fire_pending = 1'b0;
  int            cyc = 0;
  int            cs_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic present();
    eq_dv    = (src_q.size() != 0);
    eq_empty = (src_q.size() == 0);
    eq_ev    = (src_q.size() != 0) ? src_q[0] : '0;
  endtask

  // Expected sim_time at issue is the latest TIME seen so far: time only
  // moves forward, and late entries go out at the current time.
  task automatic load(input logic [TW-1:0] t);
    logic [31:0] r;
    exp_t        e;
    r    = $urandom;
    e.ev = {r[31:16], t};
    if (t > model_time) model_time = t;
    e.t  = model_time;
    src_q.push_back(e.ev);
    sb.push_back(e);
  endtask

  task automatic step(input logic en_v, input logic rdy_v, input logic busy_v);
    @(negedge clk);
    if (fire_pending) begin
      src_q.delete(0);
      fire_pending = 1'b0;
    end
    en         = en_v;
    ev_ready   = rdy_v;
    eq_busy_rd = busy_v;
    present();
    #1;
    if (eq_cs) begin
      fire_pending = 1'b1;
      cs_cyc.push_back(cyc);
    end
    cyc++;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || src_q.size() != 0) && n < 200) begin
      step(1'b1, 1'b1, 1'b0);
      n++;
    end
    check({name, "_drain_left"}, 32'(sb.size() + src_q.size()), 32'd0);
    repeat (4) step(1'b1, 1'b1, 1'b0);
    check({name, "_done_idle"}, 32'(done), 32'd1);
  endtask

  // ---------------- monitor ----------------
  logic          prev_cs   = 1'b0;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_head = '0;
  logic [DW-1:0] prev_out  = '0;
  logic [TW-1:0] prev_sim  = '0;
  int            mcyc      = 0;
  int            last_cs   = -100;
  exp_t          mon_e;

  always @(negedge clk) begin
    #2;
    mcyc++;
    if (!rst) begin
      prev_cs   = 1'b0;
      prev_hold = 1'b0;
      prev_sim  = '0;
      last_cs   = -100;
    end else begin
      if (prev_cs) begin
        check("lat_valid", 32'(ev_valid), 32'd1);
        check("lat_data", ev_out, prev_head);
      end
      if (prev_hold) begin
        check("hold_valid", 32'(ev_valid), 32'd1);
        check("hold_data", ev_out, prev_out);
      end
      check("sim_monotonic", 32'(sim_time >= prev_sim), 32'd1);
      check("time_adv", 32'(time_adv), 32'(sim_time != prev_sim));
      if (!eq_empty) check("done_busy", 32'(done), 32'd0);
      if (eq_cs) begin
        check("cs_spacing", 32'(mcyc - last_cs >= 3), 32'd1);
        last_cs = mcyc;
      end
      if (ev_valid && ev_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL xfer_unexpected actual=%0h required=no_transfer", ev_out);
        end else begin
          mon_e = sb.pop_front();
          check("xfer_data", ev_out, mon_e.ev);
          check("xfer_time", 32'(sim_time), 32'(mon_e.t));
        end
      end
      prev_cs   = eq_cs;
      prev_head = eq_ev;
      prev_hold = ev_valid && !ev_ready;
      prev_out  = ev_out;
      prev_sim  = sim_time;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int          c0;
    int          rc;
    int          loaded;
    logic [TW-1:0] t0;
    logic [DW-1:0] ev37;

    // reset state
    @(negedge clk);
    #1;
    check("rst_cs", 32'(eq_cs), 32'd0);
    check("rst_valid", 32'(ev_valid), 32'd0);
    check("rst_out", ev_out, 32'd0);
    check("rst_sim", 32'(sim_time), 32'd0);
    check("rst_adv", 32'(time_adv), 32'd0);
    check("rst_done", 32'(done), 32'd1);
    check("eq_op", 32'(eq_op), 32'(EXTRACT_CMD));
`ifdef TIME_CHECK_EN
    check("rst_err", 32'(err), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;

    // first extract: cs in the first cycle, valid in the next
    load(16'd0);
    ev37 = src_q[0];
    step(1'b1, 1'b1, 1'b0);
    check("r37_cs", 32'(eq_cs), 32'd1);
    step(1'b1, 1'b1, 1'b0);
    check("r37_valid", 32'(ev_valid), 32'd1);
    check("r37_out", ev_out, ev37);
    check("r37_sim", 32'(sim_time), 32'd0);
    drain("r37");

    // future head advances time, then extracts
    load(16'd5);
    step(1'b1, 1'b1, 1'b0);
    check("r38_no_cs", 32'(eq_cs), 32'd0);
    check("r38_no_adv_yet", 32'(time_adv), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    check("r38_adv", 32'(time_adv), 32'd1);
    check("r38_sim", 32'(sim_time), 32'd5);
    check("r38_cs", 32'(eq_cs), 32'd1);
    step(1'b1, 1'b1, 1'b0);
    check("r38_adv_pulse", 32'(time_adv), 32'd0);
    drain("r38");

    // three same-time events with downstream stalled
    repeat (3) load(16'd7);
    c0 = cs_cyc.size();
    repeat (10) step(1'b1, 1'b0, 1'b0);
    check("r39_one_extract", 32'(cs_cyc.size() - c0), 32'd1);
    c0 = cs_cyc.size();
    rc = cyc;
    repeat (8) step(1'b1, 1'b1, 1'b0);
    check("r39_two_more", 32'(cs_cyc.size() - c0), 32'd2);
    if (cs_cyc.size() >= c0 + 2) begin
      check("r39_first_at_ready", 32'(cs_cyc[c0]), 32'(rc));
      check("r39_spacing", 32'(cs_cyc[c0+1] - cs_cyc[c0]), 32'd3);
    end
    drain("r39");

    // queue busy after an extract holds off further extracts
    repeat (2) load(16'd7);
    step(1'b1, 1'b1, 1'b0);
    check("r40_cs", 32'(eq_cs), 32'd1);
    c0 = cs_cyc.size();
    repeat (4) step(1'b1, 1'b1, 1'b1);
    check("r40_no_cs_busy", 32'(cs_cyc.size() - c0), 32'd0);
    drain("r40");

    // late head: issued at the current time
    load(16'd9);
    drain("late_pre");
`ifdef TIME_CHECK_EN
    check("r41_err_clear", 32'(err), 32'd0);
`endif
    load(16'd4);
    drain("late");
    check("late_sim_kept", 32'(sim_time), 32'd9);
`ifdef TIME_CHECK_EN
    check("r41_err_set", 32'(err), 32'd1);
    repeat (3) step(1'b1, 1'b1, 1'b0);
    check("r41_err_sticky", 32'(err), 32'd1);
`endif

    // reset while SETTLE holds a valid event
    repeat (2) load(16'd20);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("r42_cs", 32'(eq_cs), 32'd1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check("r42_pre_valid", 32'(ev_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("r42_cs0", 32'(eq_cs), 32'd0);
    check("r42_valid0", 32'(ev_valid), 32'd0);
    check("r42_out0", ev_out, 32'd0);
    check("r42_sim0", 32'(sim_time), 32'd0);
    check("r42_adv0", 32'(time_adv), 32'd0);
    check("r42_done_q_busy", 32'(done), 32'd0);
`ifdef TIME_CHECK_EN
    check("r42_err0", 32'(err), 32'd0);
`endif
    src_q.delete();
    sb.delete();
    model_time   = '0;
    fire_pending = 1'b0;
    present();
    #1;
    check("r42_done_empty", 32'(done), 32'd1);
    @(negedge clk);
    rst = 1'b1;

    // randomized traffic
    loaded = 0;
    for (int i = 0; i < 700; i++) begin
      if (loaded < 150 && $urandom_range(0, 2) == 0) begin
        t0 = model_time + 16'($urandom_range(0, 3));
        load(t0);
        loaded++;
      end
      step(1'($urandom_range(0, 9) != 0),
           1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 4) == 0));
    end
    drain("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
